large_array_arbiter: RTL and testbench

//  - Two-requester arbiter and sequencer for the single-port AW x DW LargeArray store (16x8 by default).
//  - Grants one access per cycle (write, or read with 1-cycle registered return), round-robin by default.
//  - Keeps an ILA-style saturating "cycles since last write" counter for the verification harness.
//  - Sits between the vpipe front-end requesters and the array model; it owns the storage array.

---
 rtl/large_array_arbiter.sv | 115 +++++++++++
 tb/tb_large_array_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/large_array_arbiter.sv
// Two-requester arbiter/sequencer owning a single-port 2**AW x DW store, with a
// saturating cycles-since-last-write counter. Define LARB_FIXED_PRIO_EN for fixed priority (req0 wins).
module large_array_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid,
  output logic          rid,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [CW-1:0] wr_cnt
);

  typedef enum logic {IDLE, RD_RSP} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state;
  logic [DW-1:0] mem [2**AW];
  logic          any_gnt;
  logic          sel_id;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          wr_go;
  logic          rd_go;

`ifndef LARB_FIXED_PRIO_EN
  logic          rr_ptr;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
`ifdef LARB_FIXED_PRIO_EN
      gnt0 = req0;
      gnt1 = req1 & ~req0;
`else
      if (req0 && req1) begin
        gnt0 = ~rr_ptr;
        gnt1 = rr_ptr;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
`endif
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign sel_id    = gnt1;
  assign sel_we    = gnt1 ? we1    : we0;
  assign sel_addr  = gnt1 ? addr1  : addr0;
  assign sel_wdata = gnt1 ? wdata1 : wdata0;
  assign wr_go     = any_gnt & sel_we;
  assign rd_go     = any_gnt & ~sel_we;

  // NOTE: the storage array has no reset so it maps onto plain RAM; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (wr_go) mem[sel_addr] <= sel_wdata;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rvalid <= 1'b0;
      busy   <= 1'b0;
      rid    <= 1'b0;
      rdata  <= '0;
      wr_cnt <= '0;
`ifndef LARB_FIXED_PRIO_EN
      rr_ptr <= 1'b0;
`endif
    end else begin
`ifndef LARB_FIXED_PRIO_EN
      if (any_gnt) rr_ptr <= ~sel_id;
`endif
      // Writes granted while a response is outstanding leave rdata/rid untouched.
      if (rd_go) begin
        rdata <= mem[sel_addr];
        rid   <= sel_id;
      end

      case (state)
        IDLE:    if (rd_go)  state <= RD_RSP;
        RD_RSP:  if (!rd_go) state <= IDLE;
        default: state <= IDLE;
      endcase
      rvalid <= rd_go;
      busy   <= rd_go;

      if (wr_go)
        wr_cnt <= CW'(1);
      else if (wr_cnt != '0 && wr_cnt != CNT_MAX)
        wr_cnt <= wr_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_large_array_arbiter.sv
// Self-checking bench for large_array_arbiter: a table of per-cycle vectors plus
// hand-written sequences for reset, counter saturation and contention.
module tb_large_array_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid, rid, busy;
  logic [7:0] rdata, wr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  large_array_arbiter #(.AW(4), .DW(8), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1),
    .rvalid(rvalid), .rid(rid), .rdata(rdata), .busy(busy), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       req0, we0;
    logic [3:0] addr0;
    logic [7:0] wdata0;
    logic       req1, we1;
    logic [3:0] addr1;
    logic [7:0] wdata1;
    logic       g0, g1;
    logic       rv, rid;
    logic [7:0] rdata;
    logic       busy;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [3:0] a1, input logic [7:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  initial begin
    //             req0  we0   a0     d0      req1  we1   a1     d1      g0    g1    rv    rid   rdata   busy  cnt
    tbl[0]  = '{1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd1};
    tbl[1]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd1};
    tbl[2]  = '{1'b1, 1'b1, 4'd2, 8'h22, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd1};
    tbl[3]  = '{1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 8'd2};
    tbl[4]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'd3};
    tbl[5]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd7, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 8'd1};
    tbl[6]  = '{1'b1, 1'b0, 4'd7, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 8'd2};
    tbl[7]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 8'd3};
    tbl[8]  = '{1'b1, 1'b1, 4'd5, 8'h55, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 8'd1};
    tbl[9]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 8'd2};
    tbl[10] = '{1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 8'd3};

    // Reset with both requesters active: nothing may be granted.
    rst = 1'b1;
    drive(1'b1, 1'b1, 4'd0, 8'h00, 1'b1, 1'b1, 4'd0, 8'h00);
    edge1();
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_gnt1", 32'(gnt1), 32'd0);
    edge1();
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_rid",    32'(rid),    32'd0);
    check("rst_rdata",  32'(rdata),  32'd0);
    check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    #2;
    check("idle_gnt0", 32'(gnt0), 32'd0);
    edge1();

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].req0, tbl[i].we0, tbl[i].addr0, tbl[i].wdata0,
            tbl[i].req1, tbl[i].we1, tbl[i].addr1, tbl[i].wdata1);
      #2;
      check($sformatf("v%0d_gnt0", i), 32'(gnt0), 32'(tbl[i].g0));
      check($sformatf("v%0d_gnt1", i), 32'(gnt1), 32'(tbl[i].g1));
      edge1();
      check($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
      check($sformatf("v%0d_rid", i),    32'(rid),    32'(tbl[i].rid));
      check($sformatf("v%0d_rdata", i),  32'(rdata),  32'(tbl[i].rdata));
      check($sformatf("v%0d_busy", i),   32'(busy),   32'(tbl[i].busy));
      check($sformatf("v%0d_wr_cnt", i), 32'(wr_cnt), 32'(tbl[i].cnt));
    end

    // wr_cnt counts up from 1 after a write and saturates at 255.
    drive(1'b1, 1'b1, 4'd4, 8'h44, 1'b0, 1'b0, 4'd0, 8'h00);
    #2;
    check("sat_gnt0", 32'(gnt0), 32'd1);
    edge1();
    check("sat_cnt_start", 32'(wr_cnt), 32'd1);
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    for (int n = 1; n <= 258; n++) begin
      edge1();
      check($sformatf("sat_cnt_%0d", n), 32'(wr_cnt), (n + 1 > 255) ? 32'd255 : 32'(n + 1));
    end

    // Read granted, then reset arrives: response dropped, no grants under reset.
    drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    #2;
    check("mid_gnt0", 32'(gnt0), 32'd1);
    edge1();
    check("mid_rvalid", 32'(rvalid), 32'd1);
    check("mid_rdata",  32'(rdata),  32'hA5);
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 1'b0, 4'd2, 8'h00);
    #2;
    check("mid_rst_gnt0", 32'(gnt0), 32'd0);
    check("mid_rst_gnt1", 32'(gnt1), 32'd0);
    edge1();
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_busy",   32'(busy),   32'd0);
    check("mid_rst_wr_cnt", 32'(wr_cnt), 32'd0);
    check("mid_rst_gnt0b",  32'(gnt0),   32'd0);
    rst = 1'b0;

    // Both requesters hold reads of addr 1 / addr 2 from a fresh reset.
    for (int i = 0; i < 6; i++) begin
      logic exp_g0;
`ifdef LARB_FIXED_PRIO_EN
      exp_g0 = 1'b1;
`else
      exp_g0 = (i % 2 == 0);
`endif
      #2;
      check($sformatf("cont%0d_gnt0", i), 32'(gnt0), 32'(exp_g0));
      check($sformatf("cont%0d_gnt1", i), 32'(gnt1), 32'(!exp_g0));
      edge1();
      check($sformatf("cont%0d_rvalid", i), 32'(rvalid), 32'd1);
      check($sformatf("cont%0d_busy", i),   32'(busy),   32'd1);
      check($sformatf("cont%0d_rid", i),    32'(rid),    32'(!exp_g0));
      check($sformatf("cont%0d_rdata", i),  32'(rdata),  exp_g0 ? 32'h11 : 32'h22);
    end

    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    edge1();
    check("end_rvalid", 32'(rvalid), 32'd0);
    check("end_busy",   32'(busy),   32'd0);
    check("end_rdata",  32'(rdata),  32'h22);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
